uart_baud_sched: RTL and testbench



---
 rtl/uart_baud_sched.sv | 179 +++++++++++++++++
 tb/tb_uart_baud_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_sched.sv
// uart_baud_sched: baud-clock scheduler for the UART core.
// Owns the bit-rate divisor, accepts new divisors over a valid/ready
// handshake and only switches divisor on a bit boundary, so every bit period
// is timed with one divisor. Generates the TX bit tick, the RX oversample
// tick and the tx_clk bit-rate square wave.
//
// Optional build macro: UART_BAUD_SCHED_ASSERT_EN compiles in SVA checkers.
// With it undefined the functional behaviour is identical.
//
// Config handshake: a transfer happens on a rising clk edge where
// cfg_valid && cfg_ready. cfg_ready is high in IDLE and RUN and low in PEND,
// so at most one divisor can be waiting for a bit boundary. A transferred
// divisor below MIN_DIV is dropped and reported by a one-cycle cfg_err pulse
// on the following cycle.
module uart_baud_sched #(
  parameter int BAUDRATE_CONFIG_BITWIDTH = 17,
  parameter int OVERSAMPLE               = 16,
  parameter int MIN_DIV                  = OVERSAMPLE
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [BAUDRATE_CONFIG_BITWIDTH-1:0] cfg_baud,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  output logic                                cfg_err,
  input  logic                                enable,
  output logic [BAUDRATE_CONFIG_BITWIDTH-1:0] active_baud,
  output logic                                tx_tick,
  output logic                                rx_tick,
  output logic                                tx_clk,
  output logic [1:0]                          dbg_state
);

  localparam int W      = BAUDRATE_CONFIG_BITWIDTH;
  localparam int OS_LOG = $clog2(OVERSAMPLE);
  localparam int NUM_W  = $clog2(OVERSAMPLE + 1);

  localparam logic [W-1:0]     W_ONE    = W'(1);
  localparam logic [W-1:0]     W_MIN    = W'(MIN_DIV);
  localparam logic [NUM_W-1:0] NUM_ONE  = NUM_W'(1);
  localparam logic [NUM_W-1:0] NUM_MAX  = NUM_W'(OVERSAMPLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no divisor loaded
    ST_RUN  = 2'd1,  // timing with active_baud
    ST_PEND = 2'd2   // new divisor waiting for the next bit boundary
  } state_t;

  state_t           state;
  logic [W-1:0]     pend_baud;
  logic [W-1:0]     bit_cnt;
  logic [W-1:0]     os_cnt;
  logic [NUM_W-1:0] os_num;

  logic [W-1:0]     os_div;
  logic             running;
  logic             bit_last;
  logic             os_last;
  logic             xfer;
  logic             div_ok;
  logic             apply_pend;

  // Decode of the registered state into ticks, handshake and switch control.
  always_comb begin
    os_div     = active_baud >> OS_LOG;
    running    = (state != ST_IDLE) && enable;
    bit_last   = (bit_cnt == (active_baud - W_ONE));
    os_last    = (os_cnt == (os_div - W_ONE));
    cfg_ready  = (state != ST_PEND);
    xfer       = cfg_valid && cfg_ready;
    div_ok     = (cfg_baud >= W_MIN);
    tx_tick    = running && bit_last;
    // Remainder cycles of a divisor that is not a multiple of OVERSAMPLE
    // would produce extra ticks; os_num caps them at OVERSAMPLE per bit.
    rx_tick    = running && os_last && (os_num < NUM_MAX);
    tx_clk     = running && (bit_cnt < (active_baud >> 1));
    // The pending divisor goes live on a bit boundary, or straight away
    // when timing is stopped because there is no bit in flight to protect.
    apply_pend = (state == ST_PEND) && (tx_tick || !enable);
    dbg_state  = state;
  end

  // Divisor FSM: loads, parks and applies divisors and flags rejected ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      active_baud <= '0;
      pend_baud   <= '0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= xfer && !div_ok;
      case (state)
        ST_IDLE: begin
          if (xfer && div_ok) begin
            active_baud <= cfg_baud;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (xfer && div_ok) begin
            pend_baud <= cfg_baud;
            state     <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (apply_pend) begin
            active_baud <= pend_baud;
            state       <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bit and oversample counters; all restart together at each bit boundary,
  // whenever timing is stopped, and when a new divisor takes effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      os_cnt  <= '0;
      os_num  <= '0;
    end else if (!running || apply_pend || bit_last) begin
      bit_cnt <= '0;
      os_cnt  <= '0;
      os_num  <= '0;
    end else begin
      bit_cnt <= bit_cnt + W_ONE;
      if (os_last) begin
        os_cnt <= '0;
        if (os_num < NUM_MAX) begin
          os_num <= os_num + NUM_ONE;
        end
      end else begin
        os_cnt <= os_cnt + W_ONE;
      end
    end
  end

`ifdef UART_BAUD_SCHED_ASSERT_EN
  localparam int CHK_W = NUM_W + 1;

  logic [CHK_W-1:0] chk_rx_cnt;
  logic [CHK_W-1:0] chk_rx_total;

  assign chk_rx_total = chk_rx_cnt + CHK_W'(rx_tick);

  // Counts rx_ticks since the last bit boundary for the per-bit check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_rx_cnt <= '0;
    end else if (!running || tx_tick) begin
      chk_rx_cnt <= '0;
    end else if (rx_tick) begin
      chk_rx_cnt <= chk_rx_cnt + CHK_W'(1);
    end
  end

  a_clk_in_rst: assert property (@(posedge clk) rst |-> !tx_clk)
    else $error("uart_baud_sched: tx_clk high during reset");

  a_tick_gap: assert property (@(posedge clk) disable iff (rst)
    tx_tick |=> !tx_tick)
    else $error("uart_baud_sched: tx_tick high on consecutive cycles");

  a_rx_per_bit: assert property (@(posedge clk) disable iff (rst)
    tx_tick |-> (chk_rx_total == CHK_W'(OVERSAMPLE)))
    else $error("uart_baud_sched: rx_tick count per bit is not OVERSAMPLE");

  a_ready_pend: assert property (@(posedge clk) disable iff (rst)
    cfg_ready == (state != ST_PEND))
    else $error("uart_baud_sched: cfg_ready low outside PEND");

  a_min_div: assert property (@(posedge clk) disable iff (rst)
    (state != ST_IDLE) |-> (active_baud >= W_MIN))
    else $error("uart_baud_sched: active_baud below MIN_DIV while loaded");
`endif

endmodule

// File: tb/tb_uart_baud_sched.sv
// Bench for uart_baud_sched: scenario tasks called in sequence, expected
// tick positions queued when a divisor is driven and matched against the
// ticks captured from the DUT.
module tb_uart_baud_sched;

  localparam int W = 17;

  logic         clk;
  logic         rst;
  logic [W-1:0] cfg_baud;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         cfg_err;
  logic         enable;
  logic [W-1:0] active_baud;
  logic         tx_tick;
  logic         rx_tick;
  logic         tx_clk;
  logic [1:0]   dbg_state;

  int n_checks;
  int n_errors;
  int hi_total;

  logic [15:0] exp_q[$];
  logic [15:0] tick_q[$];
  logic [15:0] rx_q[$];
  logic [15:0] hi_q[$];
  logic        rx_trace [0:255];

  uart_baud_sched #(
    .BAUDRATE_CONFIG_BITWIDTH(W),
    .OVERSAMPLE(16),
    .MIN_DIV(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_baud(cfg_baud),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_err(cfg_err),
    .enable(enable),
    .active_baud(active_baud),
    .tx_tick(tx_tick),
    .rx_tick(rx_tick),
    .tx_clk(tx_clk),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Captures ncyc cycles starting with the current one: tick positions and,
  // for each completed bit, the rx_tick and tx_clk-high counts.
  task automatic watch(input int ncyc);
    int rx_n;
    int hi_n;
    rx_n = 0;
    hi_n = 0;
    hi_total = 0;
    tick_q.delete();
    rx_q.delete();
    hi_q.delete();
    for (int j = 0; j < ncyc; j++) begin
      if (j > 0) step();
      if (j < 256) rx_trace[j] = rx_tick;
      if (rx_tick) rx_n++;
      if (tx_clk) begin
        hi_n++;
        hi_total++;
      end
      if (tx_tick) begin
        tick_q.push_back(16'(j));
        rx_q.push_back(16'(rx_n));
        hi_q.push_back(16'(hi_n));
        rx_n = 0;
        hi_n = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_baud = '0;
    enable = 1'b0;
    repeat ($urandom_range(2, 5)) step();
    n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
    n_checks++; if (cfg_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    n_checks++; if (tx_tick !== 1'b0) begin n_errors++; $display("FAIL reset_tx_tick: got %b want 0", tx_tick); end
    n_checks++; if (rx_tick !== 1'b0) begin n_errors++; $display("FAIL reset_rx_tick: got %b want 0", rx_tick); end
    n_checks++; if (tx_clk !== 1'b0) begin n_errors++; $display("FAIL reset_tx_clk: got %b want 0", tx_clk); end
    n_checks++; if (active_baud !== '0) begin n_errors++; $display("FAIL reset_active: got %0d want 0", active_baud); end
    n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst = 1'b0;
    enable = 1'b1;
    step();
    n_checks++; if (tx_clk !== 1'b0 || tx_tick !== 1'b0) begin n_errors++; $display("FAIL idle_enabled_quiet: got tx_clk=%b tx_tick=%b want 0/0", tx_clk, tx_tick); end
  endtask

  task automatic test_load_32();
    logic [15:0] e;
    logic [15:0] o;
    cfg_baud = 32;
    cfg_valid = 1'b1;
    exp_q.push_back(16'd31);
    exp_q.push_back(16'd63);
    exp_q.push_back(16'd95);
    step();
    cfg_valid = 1'b0;
    n_checks++; if (active_baud !== 17'd32) begin n_errors++; $display("FAIL load32_active: got %0d want 32", active_baud); end
    n_checks++; if (dbg_state !== 2'd1) begin n_errors++; $display("FAIL load32_state: got %0d want 1", dbg_state); end
    watch(96);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (tick_q.size() == 0) begin n_errors++; $display("FAIL load32_tick: got none want tick at %0d", e); end
      else begin o = tick_q.pop_front(); if (o !== e) begin n_errors++; $display("FAIL load32_tick: got %0d want %0d", o, e); end end
    end
    n_checks++; if (tick_q.size() != 0) begin n_errors++; $display("FAIL load32_extra_tick: got %0d extra want 0", tick_q.size()); end
    foreach (rx_q[i]) begin n_checks++; if (rx_q[i] !== 16'd16) begin n_errors++; $display("FAIL load32_rx_per_bit: got %0d want 16", rx_q[i]); end end
    foreach (hi_q[i]) begin n_checks++; if (hi_q[i] !== 16'd16) begin n_errors++; $display("FAIL load32_clk_high: got %0d want 16", hi_q[i]); end end
    for (int j = 0; j < 32; j++) begin
      n_checks++;
      if (rx_trace[j] !== ((j % 2) == 1)) begin n_errors++; $display("FAIL load32_rx_spacing: cycle %0d got %b want %b", j, rx_trace[j], ((j % 2) == 1)); end
    end
  endtask

  task automatic test_reconfig_64();
    logic [15:0] e;
    logic [15:0] o;
    int          low;
    logic        last_tick;
    repeat (10) step();
    n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL reconfig_ready_before: got %b want 1", cfg_ready); end
    cfg_baud = 64;
    cfg_valid = 1'b1;
    exp_q.push_back(16'd63);
    step();
    cfg_valid = 1'b0;
    n_checks++; if (active_baud !== 17'd32) begin n_errors++; $display("FAIL reconfig_active_hold: got %0d want 32", active_baud); end
    low = 0;
    last_tick = 1'b0;
    for (int k = 0; k < 200 && cfg_ready === 1'b0; k++) begin
      low++;
      last_tick = tx_tick;
      step();
    end
    n_checks++; if (low != 22) begin n_errors++; $display("FAIL reconfig_ready_low: got %0d cycles want 22", low); end
    n_checks++; if (last_tick !== 1'b1) begin n_errors++; $display("FAIL reconfig_boundary_tick: got %b want 1", last_tick); end
    n_checks++; if (active_baud !== 17'd64) begin n_errors++; $display("FAIL reconfig_active_new: got %0d want 64", active_baud); end
    n_checks++; if (dbg_state !== 2'd1) begin n_errors++; $display("FAIL reconfig_state: got %0d want 1", dbg_state); end
    watch(64);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (tick_q.size() == 0) begin n_errors++; $display("FAIL reconfig_tick: got none want tick at %0d", e); end
      else begin o = tick_q.pop_front(); if (o !== e) begin n_errors++; $display("FAIL reconfig_tick: got %0d want %0d", o, e); end end
    end
    n_checks++; if (tick_q.size() != 0) begin n_errors++; $display("FAIL reconfig_extra_tick: got %0d extra want 0", tick_q.size()); end
    foreach (rx_q[i]) begin n_checks++; if (rx_q[i] !== 16'd16) begin n_errors++; $display("FAIL reconfig_rx_per_bit: got %0d want 16", rx_q[i]); end end
    foreach (hi_q[i]) begin n_checks++; if (hi_q[i] !== 16'd32) begin n_errors++; $display("FAIL reconfig_clk_high: got %0d want 32", hi_q[i]); end end
  endtask

  task automatic test_cfg_err();
    logic [15:0] e;
    logic [15:0] o;
    step();
    cfg_baud = 15;
    cfg_valid = 1'b1;
    exp_q.push_back(16'd61);
    step();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_err !== 1'b1) begin n_errors++; $display("FAIL err_pulse: got %b want 1", cfg_err); end
    n_checks++; if (active_baud !== 17'd64) begin n_errors++; $display("FAIL err_active: got %0d want 64", active_baud); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL err_ready: got %b want 1", cfg_ready); end
    n_checks++; if (dbg_state !== 2'd1) begin n_errors++; $display("FAIL err_state: got %0d want 1", dbg_state); end
    step();
    n_checks++; if (cfg_err !== 1'b0) begin n_errors++; $display("FAIL err_one_cycle: got %b want 0", cfg_err); end
    watch(62);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (tick_q.size() == 0) begin n_errors++; $display("FAIL err_tick: got none want tick at %0d", e); end
      else begin o = tick_q.pop_front(); if (o !== e) begin n_errors++; $display("FAIL err_tick: got %0d want %0d", o, e); end end
    end
    n_checks++; if (tick_q.size() != 0) begin n_errors++; $display("FAIL err_extra_tick: got %0d extra want 0", tick_q.size()); end
  endtask

  task automatic test_enable_drop_pend();
    logic [15:0] e;
    logic [15:0] o;
    step();
    cfg_baud = 32;
    cfg_valid = 1'b1;
    exp_q.push_back(16'd31);
    step();
    cfg_valid = 1'b0;
    repeat (4) step();
    n_checks++; if (dbg_state !== 2'd2 || cfg_ready !== 1'b0) begin n_errors++; $display("FAIL drop_in_pend: got state=%0d ready=%b want 2/0", dbg_state, cfg_ready); end
    enable = 1'b0;
    step();
    n_checks++; if (tx_tick !== 1'b0 || rx_tick !== 1'b0 || tx_clk !== 1'b0) begin n_errors++; $display("FAIL drop_outputs: got tx=%b rx=%b clk=%b want 0/0/0", tx_tick, rx_tick, tx_clk); end
    n_checks++; if (active_baud !== 17'd32) begin n_errors++; $display("FAIL drop_applied: got %0d want 32", active_baud); end
    n_checks++; if (cfg_ready !== 1'b1 || dbg_state !== 2'd1) begin n_errors++; $display("FAIL drop_state: got ready=%b state=%0d want 1/1", cfg_ready, dbg_state); end
    repeat ($urandom_range(1, 4)) begin
      step();
      n_checks++; if (tx_clk !== 1'b0 || tx_tick !== 1'b0) begin n_errors++; $display("FAIL drop_quiet: got clk=%b tick=%b want 0/0", tx_clk, tx_tick); end
    end
    enable = 1'b1;
    #1;
    watch(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (tick_q.size() == 0) begin n_errors++; $display("FAIL reenable_tick: got none want tick at %0d", e); end
      else begin o = tick_q.pop_front(); if (o !== e) begin n_errors++; $display("FAIL reenable_tick: got %0d want %0d", o, e); end end
    end
    n_checks++; if (tick_q.size() != 0) begin n_errors++; $display("FAIL reenable_extra_tick: got %0d extra want 0", tick_q.size()); end
    foreach (rx_q[i]) begin n_checks++; if (rx_q[i] !== 16'd16) begin n_errors++; $display("FAIL reenable_rx_per_bit: got %0d want 16", rx_q[i]); end end
    foreach (hi_q[i]) begin n_checks++; if (hi_q[i] !== 16'd16) begin n_errors++; $display("FAIL reenable_clk_high: got %0d want 16", hi_q[i]); end end
  endtask

  task automatic test_enable_fall_on_tick();
    logic [15:0] e;
    logic [15:0] o;
    logic        found;
    step();
    cfg_baud = 16;
    cfg_valid = 1'b1;
    exp_q.push_back(16'd15);
    step();
    cfg_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (tx_tick === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL fall_tick_seen: got %b want 1", found); end
    enable = 1'b0;
    step();
    n_checks++; if (active_baud !== 17'd16) begin n_errors++; $display("FAIL fall_tick_applied: got %0d want 16", active_baud); end
    n_checks++; if (tx_tick !== 1'b0 || tx_clk !== 1'b0) begin n_errors++; $display("FAIL fall_tick_quiet: got tick=%b clk=%b want 0/0", tx_tick, tx_clk); end
    n_checks++; if (dbg_state !== 2'd1) begin n_errors++; $display("FAIL fall_tick_state: got %0d want 1", dbg_state); end
    step();
    n_checks++; if (tx_tick !== 1'b0) begin n_errors++; $display("FAIL fall_tick_no_more: got %b want 0", tx_tick); end
    enable = 1'b1;
    #1;
    watch(16);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (tick_q.size() == 0) begin n_errors++; $display("FAIL min_div_tick: got none want tick at %0d", e); end
      else begin o = tick_q.pop_front(); if (o !== e) begin n_errors++; $display("FAIL min_div_tick: got %0d want %0d", o, e); end end
    end
    n_checks++; if (tick_q.size() != 0) begin n_errors++; $display("FAIL min_div_extra_tick: got %0d extra want 0", tick_q.size()); end
    foreach (rx_q[i]) begin n_checks++; if (rx_q[i] !== 16'd16) begin n_errors++; $display("FAIL min_div_rx_per_bit: got %0d want 16", rx_q[i]); end end
    foreach (hi_q[i]) begin n_checks++; if (hi_q[i] !== 16'd8) begin n_errors++; $display("FAIL min_div_clk_high: got %0d want 8", hi_q[i]); end end
  endtask

  task automatic test_reset_mid_run();
    step();
    n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL mid_ready_before: got %b want 1", cfg_ready); end
    cfg_baud = 64;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_ready !== 1'b0 || tx_clk !== 1'b1) begin n_errors++; $display("FAIL mid_pend_running: got ready=%b clk=%b want 0/1", cfg_ready, tx_clk); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL mid_rst_ready: got %b want 1", cfg_ready); end
    n_checks++; if (tx_clk !== 1'b0) begin n_errors++; $display("FAIL mid_rst_tx_clk: got %b want 0", tx_clk); end
    n_checks++; if (tx_tick !== 1'b0 || rx_tick !== 1'b0 || cfg_err !== 1'b0) begin n_errors++; $display("FAIL mid_rst_pulses: got tx=%b rx=%b err=%b want 0/0/0", tx_tick, rx_tick, cfg_err); end
    n_checks++; if (active_baud !== '0) begin n_errors++; $display("FAIL mid_rst_active: got %0d want 0", active_baud); end
    n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL mid_rst_state: got %0d want 0", dbg_state); end
    step();
    rst = 1'b0;
    step();
    watch(80);
    n_checks++; if (tick_q.size() != 0) begin n_errors++; $display("FAIL mid_rst_pending_dropped: got %0d ticks want 0", tick_q.size()); end
    n_checks++; if (hi_total != 0) begin n_errors++; $display("FAIL mid_rst_idle_clk: got %0d high cycles want 0", hi_total); end
  endtask

  task automatic test_load_17();
    logic [15:0] e;
    logic [15:0] o;
    cfg_baud = 17;
    cfg_valid = 1'b1;
    exp_q.push_back(16'd16);
    exp_q.push_back(16'd33);
    step();
    cfg_valid = 1'b0;
    n_checks++; if (active_baud !== 17'd17) begin n_errors++; $display("FAIL load17_active: got %0d want 17", active_baud); end
    watch(34);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (tick_q.size() == 0) begin n_errors++; $display("FAIL load17_tick: got none want tick at %0d", e); end
      else begin o = tick_q.pop_front(); if (o !== e) begin n_errors++; $display("FAIL load17_tick: got %0d want %0d", o, e); end end
    end
    n_checks++; if (tick_q.size() != 0) begin n_errors++; $display("FAIL load17_extra_tick: got %0d extra want 0", tick_q.size()); end
    foreach (rx_q[i]) begin n_checks++; if (rx_q[i] !== 16'd16) begin n_errors++; $display("FAIL load17_rx_per_bit: got %0d want 16", rx_q[i]); end end
    foreach (hi_q[i]) begin n_checks++; if (hi_q[i] !== 16'd8) begin n_errors++; $display("FAIL load17_clk_high: got %0d want 8", hi_q[i]); end end
    n_checks++; if (rx_trace[15] !== 1'b1) begin n_errors++; $display("FAIL load17_rx_16th: got %b want 1", rx_trace[15]); end
    n_checks++; if (rx_trace[16] !== 1'b0) begin n_errors++; $display("FAIL load17_rx_17th_suppressed: got %b want 0", rx_trace[16]); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    hi_total = 0;
    test_reset();
    test_load_32();
    test_reconfig_64();
    test_cfg_err();
    test_enable_drop_pend();
    test_enable_fall_on_tick();
    test_reset_mid_run();
    test_load_17();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
